// File: rtl/error_conv_check.sv
// Convergence checker: snapshots 16 |error| elements, scans them serially for the max and
// compares it to a threshold. Optional ERR_CONV_SUM_EN adds a sum_err output.
module error_conv_check #(
  parameter int unsigned WIDTH    = 26,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic              clk_conv,
  input  logic              rstn_conv,
  input  logic              en_conv,
  input  logic              start,
  input  logic              clr_iter,
  input  logic [WIDTH-1:0]  thr,
  input  logic [WIDTH-1:0]  i11, i12, i13, i14,
  input  logic [WIDTH-1:0]  i21, i22, i23, i24,
  input  logic [WIDTH-1:0]  i31, i32, i33, i34,
  input  logic [WIDTH-1:0]  i41, i42, i43, i44,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [WIDTH-1:0]  max_err,
  output logic [ITER_W-1:0] iter_cnt,
`ifdef ERR_CONV_SUM_EN
  output logic [WIDTH+3:0]  sum_err,
`endif
  output logic              timeout
);

  typedef enum logic [1:0] {StIdle, StScan, StDecide} state_e;

  localparam logic [WIDTH-1:0]  MagMax  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [ITER_W-1:0] IterMax = ITER_W'(MAX_ITER);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [WIDTH-1:0]   snap_q [16];
  logic [WIDTH-1:0]   snap_d [16];
  logic [WIDTH-1:0]   in_vec [16];
  logic [WIDTH-1:0]   run_max_q, run_max_d;
  logic [WIDTH-1:0]   max_err_q, max_err_d;
  logic               done_q, done_d;
  logic               conv_q, conv_d;
  logic               timeout_q, timeout_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [WIDTH-1:0]   cur_raw, cur_mag;
  logic               verdict;

  assign in_vec = '{i11, i12, i13, i14, i21, i22, i23, i24,
                    i31, i32, i33, i34, i41, i42, i43, i44};

  assign cur_raw = snap_q[idx_q];
  // Negative elements are fail-safe: treated as the largest positive magnitude.
  assign cur_mag = cur_raw[WIDTH-1] ? MagMax : cur_raw;
  assign verdict = $signed(run_max_q) <= $signed(thr);

`ifdef ERR_CONV_SUM_EN
  logic [WIDTH+3:0] acc_q, acc_d, sum_q, sum_d;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    run_max_d = run_max_q;
    max_err_d = max_err_q;
    done_d    = 1'b0;
    conv_d    = conv_q;
    timeout_d = timeout_q;
    iter_d    = iter_q;
`ifdef ERR_CONV_SUM_EN
    acc_d     = acc_q;
    sum_d     = sum_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          snap_d    = in_vec;
          run_max_d = '0;
          idx_d     = 4'd0;
          state_d   = StScan;
`ifdef ERR_CONV_SUM_EN
          acc_d     = '0;
`endif
        end
      end
      StScan: begin
        if ($signed(cur_mag) > $signed(run_max_q)) run_max_d = cur_mag;
`ifdef ERR_CONV_SUM_EN
        acc_d = acc_q + {4'b0000, cur_mag};
`endif
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = StDecide;
      end
      StDecide: begin
        max_err_d = run_max_q;
        conv_d    = verdict;
        done_d    = 1'b1;
        state_d   = StIdle;
`ifdef ERR_CONV_SUM_EN
        sum_d     = acc_q;
`endif
        if (!verdict) begin
          if (iter_q < IterMax) iter_d = iter_q + 1'b1;
          if (iter_q >= IterMax - 1'b1) timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A new ICA run overrides any increment from the verdict on the same edge.
    if (clr_iter) begin
      iter_d    = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_conv or negedge rstn_conv) begin
    if (!rstn_conv) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      snap_q    <= '{default: '0};
      run_max_q <= '0;
      max_err_q <= '0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      timeout_q <= 1'b0;
      iter_q    <= '0;
`ifdef ERR_CONV_SUM_EN
      acc_q     <= '0;
      sum_q     <= '0;
`endif
    end else if (en_conv) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      run_max_q <= run_max_d;
      max_err_q <= max_err_d;
      done_q    <= done_d;
      conv_q    <= conv_d;
      timeout_q <= timeout_d;
      iter_q    <= iter_d;
`ifdef ERR_CONV_SUM_EN
      acc_q     <= acc_d;
      sum_q     <= sum_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign converged = conv_q;
  assign max_err   = max_err_q;
  assign iter_cnt  = iter_q;
  assign timeout   = timeout_q;
`ifdef ERR_CONV_SUM_EN
  assign sum_err   = sum_q;
`endif

endmodule

// File: tb/tb_error_conv_check.sv
// Directed bench for error_conv_check: latency, verdict, fail-safe, stall, reset, timeout.
module tb_error_conv_check;
  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rstn, en, start, clr;
  logic [W-1:0] thr;
  logic [W-1:0] el [16];
  logic         busy, done, converged, timeout;
  logic [W-1:0] max_err;
  logic [7:0]   iter_cnt;
`ifdef ERR_CONV_SUM_EN
  logic [W+3:0] sum_err;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  error_conv_check dut (
    .clk_conv(clk), .rstn_conv(rstn), .en_conv(en), .start(start), .clr_iter(clr), .thr(thr),
    .i11(el[0]), .i12(el[1]), .i13(el[2]), .i14(el[3]),
    .i21(el[4]), .i22(el[5]), .i23(el[6]), .i24(el[7]),
    .i31(el[8]), .i32(el[9]), .i33(el[10]), .i34(el[11]),
    .i41(el[12]), .i42(el[13]), .i43(el[14]), .i44(el[15]),
    .busy(busy), .done(done), .converged(converged), .max_err(max_err),
    .iter_cnt(iter_cnt),
`ifdef ERR_CONV_SUM_EN
    .sum_err(sum_err),
`endif
    .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < 16; i++) el[i] = v;
  endtask

  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_eval(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    wait_done(lat);
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy, done, converged, timeout} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, done, converged, timeout});
    end
    n_tests++;
    if (max_err !== '0 || iter_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_regs got max=%0d iter=%0d want 0/0", max_err, iter_cnt);
    end
  endtask

  task automatic test_converged();
    int lat;
    set_all(W'(41)); thr = W'(82);
    run_eval(lat);
    n_tests++;
    if (lat != 17) begin n_fail++; $display("FAIL conv_latency got %0d want 17", lat); end
    n_tests++;
    if (converged !== 1'b1 || max_err !== W'(41) || iter_cnt !== 8'd0) begin
      n_fail++; $display("FAIL conv_result got c=%b max=%0d iter=%0d want 1/41/0",
                         converged, max_err, iter_cnt);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL conv_busy got %b want 0", busy); end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL conv_done_pulse got %b want 0", done); end
  endtask

  task automatic test_not_converged();
    int lat;
    set_all('0); el[6] = W'(8192);
    run_eval(lat);
    n_tests++;
    if (converged !== 1'b0 || max_err !== W'(8192) || iter_cnt !== 8'd1) begin
      n_fail++; $display("FAIL nconv_1 got c=%b max=%0d iter=%0d want 0/8192/1",
                         converged, max_err, iter_cnt);
    end
    tick();
    run_eval(lat);
    n_tests++;
    if (iter_cnt !== 8'd2) begin n_fail++; $display("FAIL nconv_2 got %0d want 2", iter_cnt); end
    tick();
  endtask

  task automatic test_negative();
    int lat;
    set_all('0); el[15] = 26'h3FF_FFFB;
    run_eval(lat);
    n_tests++;
    if (max_err !== W'(33554431) || converged !== 1'b0 || iter_cnt !== 8'd3) begin
      n_fail++; $display("FAIL negative got max=%0d c=%b iter=%0d want 33554431/0/3",
                         max_err, converged, iter_cnt);
    end
    tick();
  endtask

  task automatic test_enable_stall();
    int lat;
    set_all(W'(41));
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold got busy=%b done=%b want 1/0", busy, done);
    end
    en = 1'b1;
    lat = 10;
    wait_done(lat);
    n_tests++;
    if (lat != 22) begin n_fail++; $display("FAIL stall_latency got %0d want 22", lat); end
    n_tests++;
    if (converged !== 1'b1 || max_err !== W'(41)) begin
      n_fail++; $display("FAIL stall_result got c=%b max=%0d want 1/41", converged, max_err);
    end
    en = 1'b0; tick(); tick();
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done_stretch got %b want 1", done); end
    en = 1'b1; tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done_clear got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_all(W'(41));
    start = 1'b1; tick();
    // Inputs change after capture; first verdict must come from the snapshot.
    set_all('0); el[6] = W'(8192);
    lat = 0;
    wait_done(lat);
    n_tests++;
    if (lat != 17 || converged !== 1'b1 || max_err !== W'(41)) begin
      n_fail++; $display("FAIL b2b_first got lat=%0d c=%b max=%0d want 17/1/41",
                         lat, converged, max_err);
    end
    tick();
    lat = 1;
    wait_done(lat);
    start = 1'b0;
    n_tests++;
    if (lat != 18) begin n_fail++; $display("FAIL b2b_period got %0d want 18", lat); end
    n_tests++;
    if (converged !== 1'b0 || max_err !== W'(8192) || iter_cnt !== 8'd4) begin
      n_fail++; $display("FAIL b2b_second got c=%b max=%0d iter=%0d want 0/8192/4",
                         converged, max_err, iter_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    int seen;
    set_all(W'(41));
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rstn = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || max_err !== '0 || iter_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid got busy=%b done=%b max=%0d iter=%0d want 0/0/0/0",
                         busy, done, max_err, iter_cnt);
    end
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_no_done got %0d pulses want 0", seen); end
    run_eval(lat);
    n_tests++;
    if (lat != 17 || converged !== 1'b1 || max_err !== W'(41) || iter_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_clean_run got lat=%0d c=%b max=%0d iter=%0d want 17/1/41/0",
                         lat, converged, max_err, iter_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    int lat;
    clr = 1'b1; tick(); clr = 1'b0;
    set_all('0); el[6] = W'(8192);
    for (int i = 0; i < 254; i++) begin
      run_eval(lat);
      tick();
    end
    n_tests++;
    if (iter_cnt !== 8'd254 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL tmo_254 got iter=%0d tmo=%b want 254/0", iter_cnt, timeout);
    end
    run_eval(lat);
    n_tests++;
    if (iter_cnt !== 8'd255 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL tmo_255 got iter=%0d tmo=%b want 255/1", iter_cnt, timeout);
    end
    tick();
    run_eval(lat);
    n_tests++;
    if (iter_cnt !== 8'd255 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL tmo_saturate got iter=%0d tmo=%b want 255/1", iter_cnt, timeout);
    end
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    n_tests++;
    if (iter_cnt !== 8'd0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL tmo_clear got iter=%0d tmo=%b want 0/0", iter_cnt, timeout);
    end
    // clr_iter held across a failing verdict must win over the increment.
    clr = 1'b1;
    run_eval(lat);
    clr = 1'b0;
    n_tests++;
    if (iter_cnt !== 8'd0 || timeout !== 1'b0 || converged !== 1'b0 || max_err !== W'(8192)) begin
      n_fail++; $display("FAIL clr_priority got iter=%0d tmo=%b c=%b max=%0d want 0/0/0/8192",
                         iter_cnt, timeout, converged, max_err);
    end
    tick();
  endtask

`ifdef ERR_CONV_SUM_EN
  task automatic test_sum();
    int lat;
    set_all(W'(8192));
    run_eval(lat);
    n_tests++;
    if (sum_err !== 30'd131072) begin
      n_fail++; $display("FAIL sum_err got %0d want 131072", sum_err);
    end
    tick();
  endtask
`endif

  initial begin
    rstn = 1'b0; en = 1'b1; start = 1'b0; clr = 1'b0; thr = W'(82);
    set_all('0);
    #12;
    test_reset();
    rstn = 1'b1;
    tick();
    test_converged();
    test_not_converged();
    test_negative();
    test_enable_stall();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef ERR_CONV_SUM_EN
    test_sum();
`endif
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
